// File: rtl/demux1to4_n_pkg.sv
// Shared defaults for the 1-to-m registered demultiplexer.
// Instances override these through parameters.
package demux1to4_n_pkg;

  localparam int N_DEF       = 4;
  localparam int ADDRESS_DEF = 2;
  localparam int M_DEF       = 4;

endpackage

// File: rtl/demux1to4_n_reg_slice.sv
// One-entry output register for a single demux channel.
// A load and a drain can happen together, which keeps the channel at one word per cycle.
module reg_slice_n #(
  parameter int n = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [n-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [n-1:0] data_o,
  output logic         can_acc_o
);

  logic         full;
  logic [n-1:0] data_q;

  // The slot can take a new word when it is empty or is being drained this cycle.
  assign can_acc_o = !full || ready_i;
  assign valid_o   = full;
  assign data_o    = data_q;

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge values, whatever order the simulator runs blocks in.
  // NOTE: data_q is reset as well as full, because data_o must read 0 after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full   <= 1'b0;
      data_q <= '0;
    end else if (load_i) begin
      full   <= 1'b1;
      data_q <= data_i;
    end else if (ready_i) begin
      full   <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to4_n.sv
// Registered 1-to-m demultiplexer: one input stream steered to channel sel_i,
// each channel with its own one-entry register and valid/ready handshake.
module demux1to4_n
  import demux1to4_n_pkg::*;
#(
  parameter int n       = N_DEF,
  parameter int address = ADDRESS_DEF,
  parameter int m       = M_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [n-1:0]       data_i,
  input  logic [address-1:0] sel_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [n-1:0]       data_o [m],
  output logic [m-1:0]       valid_o,
  input  logic [m-1:0]       ready_i,
  output logic               err_o
);

  localparam int               num_sel = 1 << address;
  localparam logic [address:0] m_lim   = m[address:0];

  logic [m-1:0]       can_acc;
  logic [m-1:0]       load;
  logic [num_sel-1:0] can_acc_ext;
  logic               fire;
  logic               in_range;

  // Unused select codes read as "accepting" so out-of-range words are taken and dropped.
  // NOTE: every combinational output gets a default first, so no latch can be inferred.
  always_comb begin
    can_acc_ext        = '1;
    can_acc_ext[m-1:0] = can_acc;
  end

  assign ready_o  = can_acc_ext[sel_i];
  assign in_range = {1'b0, sel_i} < m_lim;
  assign fire     = valid_i && ready_o;

  always_comb begin
    load = '0;
    for (int k = 0; k < m; k++) begin
      load[k] = fire && (int'(sel_i) == k);
    end
  end

  for (genvar k = 0; k < m; k++) begin : g_slice
    reg_slice_n #(.n(n)) u_slice (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (load[k]),
      .data_i    (data_i),
      .ready_i   (ready_i[k]),
      .valid_o   (valid_o[k]),
      .data_o    (data_o[k]),
      .can_acc_o (can_acc[k])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else begin
      err_o <= fire && !in_range;
    end
  end

endmodule
